// File: rtl/data_mem_resp_if.sv
// Request/response bundle between the MEM stage (master) and the data memory (slave).
interface data_mem_resp_if;
    logic        ce_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic        ack_o;
    logic        err_o;
    logic [31:0] rdata_o;

    modport master (
        output ce_i, we_i, addr_i, wdata_i,
        input  busy_o, ack_o, err_o, rdata_o
    );

    modport slave (
        input  ce_i, we_i, addr_i, wdata_i,
        output busy_o, ack_o, err_o, rdata_o
    );
endinterface

// File: rtl/data_mem_resp.sv
// Data-memory responder: word-wide load/store with fixed LATENCY, flags misaligned
// and out-of-range accesses, one-cycle ack pulse.
module data_mem_resp #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    data_mem_resp_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] mem [2**ADDR_W];

    logic              accept;
    logic              commit;
    logic              cur_we;
    logic [31:0]       cur_addr;
    logic [31:0]       cur_wdata;
    logic              illegal;
    logic [ADDR_W-1:0] widx;
    logic              ack, err;
    logic [31:0]       rdata;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.ce_i) state_nxt = (LATENCY == 1) ? ACK : WAIT;
            WAIT:    if (cnt == '0) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    assign accept = (state == IDLE) && bus.ce_i;
    assign commit = (state_nxt == ACK) && (state != ACK);

    // With LATENCY==1 the accept edge is also the commit edge, so the request
    // registers are not loaded yet; take the live bus values in IDLE.
    assign cur_we    = (state == IDLE) ? bus.we_i    : req_we;
    assign cur_addr  = (state == IDLE) ? bus.addr_i  : req_addr;
    assign cur_wdata = (state == IDLE) ? bus.wdata_i : req_wdata;

    assign illegal = (cur_addr[1:0] != 2'b00) || ((cur_addr >> (ADDR_W + 2)) != 32'd0);
    assign widx    = cur_addr[ADDR_W+1:2];

    always_ff @(posedge clk) begin
        if (accept) begin
            req_we    <= bus.we_i;
            req_addr  <= bus.addr_i;
            req_wdata <= bus.wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (accept && LATENCY >= 2)
            cnt <= 4'(LATENCY - 2);
        else if (state == WAIT)
            cnt <= cnt - 4'd1;
    end

    // Array is never cleared; reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && commit && cur_we && !illegal)
            mem[widx] <= cur_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack   <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
        end else begin
            ack <= commit;
            err <= commit && illegal;
            if (commit) begin
                if (illegal)     rdata <= '0;
                else if (!cur_we) rdata <= mem[widx];
            end
        end
    end

    assign bus.busy_o  = (state != IDLE);
    assign bus.ack_o   = ack;
    assign bus.err_o   = err;
    assign bus.rdata_o = rdata;
endmodule

// File: tb/tb_data_mem_resp.sv
// Scoreboard bench for data_mem_resp: LATENCY=2 main instance plus a LATENCY=1 instance.
module tb_data_mem_resp;
    localparam int ADDR_W = 10;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_resp_if bus ();
    data_mem_resp_if bus1 ();

    data_mem_resp #(.ADDR_W(ADDR_W), .LATENCY(2)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
    data_mem_resp #(.ADDR_W(ADDR_W), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Reference model: per-instance memory and last returned rdata.
    logic [31:0] ref_mem  [2][int];
    logic [31:0] ref_rd   [2];
    exp_t        sb0[$];
    exp_t        sb1[$];
    int          cyc = 0;
    int          acks0 = 0;
    int          last_ack_cyc = 0;

    always @(posedge clk) cyc++;

    function automatic exp_t model(input int inst, input logic we, input logic [31:0] addr,
                                   input logic [31:0] data);
        exp_t e;
        int   idx;
        logic bad;
        bad = (addr[1:0] != 2'b00) || ((addr >> (ADDR_W + 2)) != 32'd0);
        idx = int'((addr >> 2) & ((32'd1 << ADDR_W) - 1));
        e.err = bad;
        if (bad)          ref_rd[inst] = '0;
        else if (we)      ref_mem[inst][idx] = data;
        else              ref_rd[inst] = ref_mem[inst].exists(idx) ? ref_mem[inst][idx] : 32'hxxxx_xxxx;
        e.rdata = ref_rd[inst];
        return e;
    endfunction

    always @(negedge clk) begin
        if (bus.ack_o) begin
            acks0++;
            last_ack_cyc = cyc;
            if (sb0.size() == 0) chk("spurious_ack0", {31'b0, bus.ack_o}, 32'd0);
            else begin
                exp_t e;
                e = sb0.pop_front();
                chk("err0",   {31'b0, bus.err_o}, {31'b0, e.err});
                chk("rdata0", bus.rdata_o, e.rdata);
            end
        end
        if (bus1.ack_o) begin
            if (sb1.size() == 0) chk("spurious_ack1", {31'b0, bus1.ack_o}, 32'd0);
            else begin
                exp_t e;
                e = sb1.pop_front();
                chk("err1",   {31'b0, bus1.err_o}, {31'b0, e.err});
                chk("rdata1", bus1.rdata_o, e.rdata);
            end
        end
    end

    task automatic drive0(input logic we, input logic [31:0] addr, input logic [31:0] data);
        sb0.push_back(model(0, we, addr, data));
        bus.ce_i = 1'b1; bus.we_i = we; bus.addr_i = addr; bus.wdata_i = data;
    endtask

    // Called right after a negedge; returns at the negedge of the ack cycle with ce_i still high.
    task automatic issue0(input logic we, input logic [31:0] addr, input logic [31:0] data);
        int n = 0;
        drive0(we, addr, data);
        do begin @(negedge clk); n++; end while (!bus.ack_o && n < 20);
        if (!bus.ack_o) chk("ack_timeout0", {31'b0, bus.ack_o}, 32'd1);
    endtask

    task automatic idle0(input int n);
        bus.ce_i = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int t1, t2, a0;
        bus.ce_i = 0; bus.we_i = 0; bus.addr_i = 0; bus.wdata_i = 0;
        bus1.ce_i = 0; bus1.we_i = 0; bus1.addr_i = 0; bus1.wdata_i = 0;
        ref_rd[0] = '0; ref_rd[1] = '0;

        // 1: reset and idle
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_busy",  {31'b0, bus.busy_o}, 32'd0);
            chk("idle_ack",   {31'b0, bus.ack_o},  32'd0);
            chk("idle_err",   {31'b0, bus.err_o},  32'd0);
            chk("idle_rdata", bus.rdata_o, 32'd0);
        end

        // 2: store timing then load-back
        drive0(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("st_c1_busy", {31'b0, bus.busy_o}, 32'd1);
        chk("st_c1_ack",  {31'b0, bus.ack_o},  32'd0);
        @(negedge clk);
        chk("st_c2_busy", {31'b0, bus.busy_o}, 32'd1);
        chk("st_c2_ack",  {31'b0, bus.ack_o},  32'd1);
        chk("st_c2_err",  {31'b0, bus.err_o},  32'd0);
        bus.ce_i = 1'b0;
        @(negedge clk);
        chk("st_c3_busy", {31'b0, bus.busy_o}, 32'd0);
        chk("st_c3_ack",  {31'b0, bus.ack_o},  32'd0);
        issue0(1'b0, 32'h0000_0010, 32'h0);
        idle0(2);

        // 3: illegal accesses leave the array intact (0x1000 would alias word 0)
        issue0(1'b1, 32'h0000_0000, 32'hA5A5_0001);
        idle0(1);
        issue0(1'b0, 32'h0000_0013, 32'h0);
        idle0(1);
        issue0(1'b1, 32'h0000_1000, 32'hBAD0_BAD0);
        idle0(1);
        issue0(1'b0, 32'h0000_0000, 32'h0);
        idle0(1);
        issue0(1'b0, 32'h8000_0004, 32'h0);
        idle0(1);

        // 4: back-to-back with ce_i held high
        a0 = acks0;
        issue0(1'b1, 32'h0000_0004, 32'h1111_1111);
        t1 = last_ack_cyc;
        issue0(1'b0, 32'h0000_0004, 32'h0);
        t2 = last_ack_cyc;
        bus.ce_i = 1'b0;
        @(negedge clk);
        chk("b2b_spacing", 32'(t2 - t1), 32'd3);
        chk("b2b_acks",    32'(acks0 - a0), 32'd2);

        // 5: reset in WAIT abandons the store
        issue0(1'b1, 32'h0000_0008, 32'h55AA_55AA);
        idle0(1);
        a0 = acks0;
        bus.ce_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 32'h8; bus.wdata_i = 32'hCAFE_F00D;
        @(negedge clk);
        chk("abort_busy_wait", {31'b0, bus.busy_o}, 32'd1);
        rst = 1'b1; bus.ce_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy",  {31'b0, bus.busy_o}, 32'd0);
        chk("abort_ack",   {31'b0, bus.ack_o},  32'd0);
        chk("abort_err",   {31'b0, bus.err_o},  32'd0);
        chk("abort_rdata", bus.rdata_o, 32'd0);
        ref_rd[0] = '0; ref_rd[1] = '0;
        repeat (3) @(negedge clk);
        chk("abort_no_ack", 32'(acks0 - a0), 32'd0);
        issue0(1'b0, 32'h0000_0008, 32'h0);
        idle0(2);

        // 6: LATENCY=1 instance
        sb1.push_back(model(1, 1'b1, 32'h3C, 32'h1234_5678));
        bus1.ce_i = 1; bus1.we_i = 1; bus1.addr_i = 32'h3C; bus1.wdata_i = 32'h1234_5678;
        @(negedge clk);
        chk("l1_st_ack", {31'b0, bus1.ack_o}, 32'd1);
        bus1.ce_i = 0;
        @(negedge clk);
        sb1.push_back(model(1, 1'b0, 32'h3C, 32'h0));
        bus1.ce_i = 1; bus1.we_i = 0;
        @(negedge clk);
        chk("l1_ld_busy", {31'b0, bus1.busy_o}, 32'd1);
        chk("l1_ld_ack",  {31'b0, bus1.ack_o},  32'd1);
        bus1.ce_i = 0;
        @(negedge clk);
        chk("l1_idle_busy", {31'b0, bus1.busy_o}, 32'd0);
        chk("l1_idle_ack",  {31'b0, bus1.ack_o},  32'd0);
        chk("l1_rdata_hold", bus1.rdata_o, 32'h1234_5678);

        repeat (2) @(negedge clk);
        chk("sb0_drained", 32'(sb0.size()), 32'd0);
        chk("sb1_drained", 32'(sb1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/data_mem_resp.md
Name: data_mem_resp

Overview:
- Responder end of the data-memory interface driven by the pipeline MEM stage.
- Accepts word-wide load/store requests (chip enable, write enable, byte address, write data).
- Holds the word-addressed storage array and returns read data with a fixed, parameterised latency.
- Flags misaligned and out-of-range accesses; the requester stalls on busy_o.

Parameters:
- ADDR_W, 10, word-address width; the array holds 2**ADDR_W 32-bit words.
- LATENCY, 2, cycles from the request-accept edge to the ack cycle; legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ce_i  input  1  request valid (MemCE).
- we_i  input  1  1 = store (sw), 0 = load (lw); sampled only at accept.
- addr_i  input  32  byte address; sampled at accept.
- wdata_i  input  32  store data; sampled at accept.
- busy_o  output  1  high while a request is in flight (state != IDLE).
- ack_o  output  1  one-cycle pulse; the request has completed.
- err_o  output  1  valid only with ack_o; the access was illegal.
- rdata_o  output  32  load data; valid when ack_o is high and the request was a load.

Behaviour:
- Reset (rst sampled high at a rising edge):
  - state -> IDLE; busy_o=0, ack_o=0, err_o=0, rdata_o=0; latency counter cleared.
  - The storage array is NOT cleared.
  - A request in flight is abandoned: no ack, and no write if the commit edge has not yet occurred.
- States: IDLE, WAIT, ACK.
- Accept: an edge where state==IDLE and ce_i==1. At that edge, latch we_i, addr_i and wdata_i into request registers.
  - LATENCY==1: IDLE->ACK.
  - LATENCY>=2: IDLE->WAIT, counter loaded with LATENCY-2.
- WAIT: decrement the counter each edge; at the edge where the counter==0, go to ACK.
- Commit edge (the edge entering ACK):
  - Legal store: array[addr[ADDR_W+1:2]] <= latched wdata.
  - Legal load: rdata_o <= array[addr[ADDR_W+1:2]].
  - Illegal access: no array write; rdata_o <= 0.
  - ack_o <= 1; err_o <= illegal.
- Illegal access: addr[1:0] != 0 (misaligned), or addr[31:ADDR_W+2] != 0 (out of range).
- ACK:
  - Lasts exactly one cycle; the next edge goes to IDLE.
  - ack_o and err_o fall to 0; rdata_o holds its value until the next load ack or reset.
  - For a store ack, rdata_o keeps its previous value.
- ce_i is ignored in WAIT and ACK. The requester must hold its request until ack_o.
- Peak throughput is one request per LATENCY+1 cycles, since IDLE must be passed through.
- ACK to accept: a ce_i high in the cycle after ACK is accepted on that edge.
- Store-then-load, same address: the load returns the new data, because the store commits before the load is accepted.
- Width rules:
  - Address bits above ADDR_W+1 are used only for the range check.
  - Data is always full 32-bit; there are no byte or halfword accesses.
- busy_o is combinational from state (state != IDLE). All other outputs are registered.

Test Plan:
1. Reset, then idle for 5 cycles with ce_i=0 -> busy_o=0, ack_o=0, err_o=0, rdata_o=0 throughout.
2. LATENCY=2, store addr=0x0000_0010, data=0xDEADBEEF accepted at edge E0 -> busy_o=1 during cycles 1-2; ack_o=1, err_o=0 in cycle 2 only. Then load 0x10 -> rdata_o=0xDEADBEEF with its ack.
3. Load addr=0x0000_0013 (misaligned), and separately store addr=0x0000_1000 (out of range for ADDR_W=10) -> each gives ack_o=1, err_o=1, rdata_o=0. A later load of word 0 shows the array unchanged.
4. Back-to-back requests with ce_i held high: store 0x4<-0x11111111 followed by load 0x4 -> accept edges exactly LATENCY+1 cycles apart; the load returns 0x11111111; exactly one ack per request.
5. Store 0x8<-0xCAFEF00D accepted, rst pulsed in WAIT before the commit edge -> no ack_o; all outputs 0 after reset; a later load 0x8 returns the pre-store value.
6. LATENCY=1 build, load of a preloaded word 0x3C=0x12345678 -> ack_o in the cycle after accept with rdata_o=0x12345678; busy_o high for exactly one cycle.
